// File: rtl/lcd_pkg.sv
// lcd_pkg: arbiter state encoding and LCD RS (data/command) levels shared by the LCD bus logic.
package lcd_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CMD  = 2'd1,
        ARB_PIX  = 2'd2,
        ARB_GAP  = 2'd3
    } arb_state_t;
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;
endpackage

// File: rtl/lcd_arb_gap_timer.sv
// lcd_arb_gap_timer: loadable down-counter; done is high while the count sits at zero.
module lcd_arb_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign done = cnt == '0;
endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares the LCD byte serializer between command and pixel channels with cs_n framing.
// Define LCD_ARB_ROUND_ROBIN_EN to alternate grants on IDLE ties instead of fixed command priority.
module lcd_bus_arbiter import lcd_pkg::*; #(
    parameter int GAP_CYCLES = 4,
    parameter int MAX_BURST  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_dc,
    input  logic       cmd_last,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_byte,
    input  logic       pix_last,
    output logic       pix_preempted,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_dc,
    output logic       cs_n,
    output logic       busy
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam arb_state_t END_STATE = (GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;

    arb_state_t state;
    logic [BW-1:0] burst;
    logic in_cmd, in_pix, preempt, cmd_xfer, pix_xfer, grant_cmd, gap_done;

    assign in_cmd = state == ARB_CMD;
    assign in_pix = state == ARB_PIX;
    // A pending command cuts a pixel burst only once the burst limit is reached.
    assign preempt = in_pix && burst == BURST_MAX && cmd_valid;

    assign cs_n          = !(in_cmd || in_pix);
    assign busy          = state != ARB_IDLE;
    assign tx_valid      = in_cmd ? cmd_valid : in_pix && !preempt && pix_valid;
    assign tx_byte       = in_cmd ? cmd_byte : in_pix ? pix_byte : 8'h00;
    assign tx_dc         = in_cmd ? cmd_dc : in_pix ? DC_DATA : DC_CMD;
    assign cmd_ready     = in_cmd && tx_ready;
    assign pix_ready     = in_pix && !preempt && tx_ready;
    assign pix_preempted = preempt;
    assign cmd_xfer      = cmd_valid && cmd_ready;
    assign pix_xfer      = pix_valid && pix_ready;

`ifdef LCD_ARB_ROUND_ROBIN_EN
    logic last_grant;  // 1 = pixel was granted last
    assign grant_cmd = cmd_valid && (!pix_valid || last_grant);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_grant <= 1'b1;
        else if (state == ARB_IDLE && (cmd_valid || pix_valid)) last_grant <= !grant_cmd;
    end
`else
    assign grant_cmd = cmd_valid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
            burst <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_cmd) state <= ARB_CMD;
                    else if (pix_valid) begin
                        state <= ARB_PIX;
                        burst <= '0;
                    end
                end
                ARB_CMD: if (cmd_xfer && cmd_last) state <= END_STATE;
                ARB_PIX: begin
                    if (preempt || (pix_xfer && pix_last)) state <= END_STATE;
                    if (pix_xfer && burst != BURST_MAX) burst <= burst + 1'b1;
                end
                ARB_GAP: if (gap_done) state <= ARB_IDLE;
                default: state <= ARB_IDLE;
            endcase
        end
    end

    lcd_arb_gap_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .reset    (reset),
        .load     ((cmd_xfer && cmd_last) || (pix_xfer && pix_last) || preempt),
        .load_val (GAP_LOAD),
        .en       (state == ARB_GAP),
        .done     (gap_done)
    );
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: vector table, corner-case sequences and a randomized stream checked against queue-based packet expectations.
module tb_lcd_bus_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic cmd_valid = 1'b0, cmd_dc = 1'b0, cmd_last = 1'b0;
    logic pix_valid = 1'b0, pix_last = 1'b0, tx_ready = 1'b0;
    logic [7:0] cmd_byte = 8'h00, pix_byte = 8'h00;
    logic cmd_ready, pix_ready, pix_preempted, tx_valid, tx_dc, cs_n, busy;
    logic [7:0] tx_byte;
    logic cmd_ready_z, pix_ready_z, pix_preempted_z, tx_valid_z, tx_dc_z, cs_n_z, busy_z;
    logic [7:0] tx_byte_z;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(.GAP_CYCLES(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte), .cmd_dc(cmd_dc), .cmd_last(cmd_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_byte(pix_byte), .pix_last(pix_last),
        .pix_preempted(pix_preempted), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
        .tx_dc(tx_dc), .cs_n(cs_n), .busy(busy)
    );

    lcd_bus_arbiter #(.GAP_CYCLES(0), .MAX_BURST(8)) dut_z (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_z), .cmd_byte(cmd_byte), .cmd_dc(cmd_dc), .cmd_last(cmd_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready_z), .pix_byte(pix_byte), .pix_last(pix_last),
        .pix_preempted(pix_preempted_z), .tx_valid(tx_valid_z), .tx_ready(tx_ready), .tx_byte(tx_byte_z),
        .tx_dc(tx_dc_z), .cs_n(cs_n_z), .busy(busy_z)
    );

    typedef struct {
        logic cv; logic [7:0] cb; logic cdc; logic cl; logic tr;
        logic cs; logic tv; logic [7:0] tb; logic tdc; logic cr; logic bz;
    } vec_t;
    typedef struct {logic [7:0] b; logic dc; logic last;} ent_t;

    vec_t vt[20];
    ent_t cq[$], pq[$], e;
    logic [7:0] got[$];
    logic [7:0] tie_exp[3];
    logic [7:0] zb[4];
    int hi_runs[$];
    int hi, pcnt, pre_cmd, pp_cnt, pp_cyc, cmd_cyc, zi, len, win_ch, ch, wbytes;
    logic cx, px, seen_low, pp_ok, exp_pp, last_seen, pp_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_byte = 8'h00; cmd_dc = 1'b0; cmd_last = 1'b0;
        pix_valid = 1'b0; pix_byte = 8'h00; pix_last = 1'b0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic track_cs(input logic cs);
        if (cs) hi++;
        else begin
            if (hi > 0 && seen_low) hi_runs.push_back(hi);
            hi = 0;
            seen_low = 1'b1;
        end
    endtask

    initial begin
        //            cv   cb     cdc  cl   tr    cs   tv   tb     tdc  cr   bz
        vt[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'h2A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 8'h3F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[8]  = vt[7];
        vt[9]  = vt[7];
        vt[10] = vt[7];
        vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1};
        vt[14] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1};
        vt[15] = vt[14];
        vt[16] = '{1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1};
        vt[17] = '{1'b0, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b1};
        vt[18] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1};
        vt[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
`ifdef LCD_ARB_ROUND_ROBIN_EN
        tie_exp = '{8'h11, 8'h55, 8'h22};
`else
        tie_exp = '{8'h11, 8'h22, 8'h55};
`endif
        zb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        // Vector table: reset state, a 5-byte command packet with its gap, then ready stalls and a valid drop.
        do_reset;
        for (int i = 0; i < 20; i++) begin
            cmd_valid = vt[i].cv; cmd_byte = vt[i].cb; cmd_dc = vt[i].cdc; cmd_last = vt[i].cl; tx_ready = vt[i].tr;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {cs_n, tx_valid, tx_byte, tx_dc, cmd_ready, pix_ready, pix_preempted, busy},
                {vt[i].cs, vt[i].tv, vt[i].tb, vt[i].tdc, vt[i].cr, 1'b0, 1'b0, vt[i].bz});
            tick;
        end

        // Tie in IDLE, with a second command raised during the first gap.
        do_reset;
        cmd_valid = 1'b1; cmd_byte = 8'h11; cmd_dc = 1'b0; cmd_last = 1'b1;
        pix_valid = 1'b1; pix_byte = 8'h55; pix_last = 1'b1; tx_ready = 1'b1;
        got.delete(); hi_runs.delete(); hi = 0; seen_low = 1'b0;
        for (int c = 0; c < 60 && got.size() < 3; c++) begin
            @(negedge clk);
            cx = cmd_valid && cmd_ready;
            px = pix_valid && pix_ready;
            track_cs(cs_n);
            if (cx || px) got.push_back(tx_byte);
            tick;
            if (cx) begin
                if (cmd_byte == 8'h11) cmd_byte = 8'h22;
                else cmd_valid = 1'b0;
            end
            if (px) pix_valid = 1'b0;
        end
        chk("tie_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("tie_order%0d", i), got[i], tie_exp[i]);
        chk("tie_gaps", hi_runs.size(), 2);
        foreach (hi_runs[i]) chk($sformatf("tie_gap_len%0d", i), hi_runs[i], 5);

        // Burst limit: 20 pixel bytes, command raised after the third.
        do_reset;
        tx_ready = 1'b1; pix_valid = 1'b1; pix_byte = 8'h00; pix_last = 1'b0;
        pcnt = 0; pre_cmd = -1; pp_cnt = 0; pp_cyc = -1; cmd_cyc = -100; pp_ok = 1'b0;
        for (int c = 0; c < 120 && pcnt < 20; c++) begin
            @(negedge clk);
            cx = cmd_valid && cmd_ready;
            px = pix_valid && pix_ready;
            if (pix_preempted) begin
                pp_cnt++;
                pp_cyc = c;
                pp_ok = !tx_valid && !pix_ready;
            end
            if (px) begin
                chk("burst_pix_order", tx_byte, pcnt);
                pcnt++;
            end
            if (cx) begin
                cmd_cyc = c;
                pre_cmd = pcnt;
            end
            tick;
            if (px) begin
                pix_byte = pix_byte + 8'd1;
                pix_last = pix_byte == 8'd19;
                if (pcnt == 20) pix_valid = 1'b0;
                if (pcnt == 3) begin
                    cmd_valid = 1'b1; cmd_byte = 8'h2C; cmd_dc = 1'b0; cmd_last = 1'b1;
                end
            end
            if (cx) cmd_valid = 1'b0;
        end
        chk("burst_pix_before_cmd", pre_cmd, 8);
        chk("burst_preempt_pulses", pp_cnt, 1);
        chk("burst_preempt_quiet", pp_ok, 1);
        chk("burst_cmd_delay", cmd_cyc - pp_cyc, 6);
        chk("burst_pix_total", pcnt, 20);

        // Reset with 2 of 4 pixel bytes sent.
        do_reset;
        tx_ready = 1'b1; pix_valid = 1'b1; pix_byte = 8'h70; pix_last = 1'b0; pcnt = 0;
        for (int c = 0; c < 10 && pcnt < 2; c++) begin
            @(negedge clk);
            px = pix_valid && pix_ready;
            if (px) pcnt++;
            tick;
            if (px) begin
                pix_byte = pix_byte + 8'd1;
                pix_last = pcnt == 3;
            end
        end
        chk("rst_mid_sent", pcnt, 2);
        chk("rst_mid_before", {cs_n, busy}, 2'b01);
        reset = 1'b1;
        #1;
        chk("rst_mid_immediate", {cs_n, tx_valid, pix_ready, busy}, 4'b1000);
        pix_valid = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_idle", {cs_n, tx_valid, busy}, 3'b100);
        chk("rst_mid_burst", 32'(dut.burst), 0);
        chk("rst_mid_gap", 32'(dut.u_gap.cnt), 0);

        // No-gap build: two back-to-back command packets.
        do_reset;
        tx_ready = 1'b1; zi = 0; hi_runs.delete(); hi = 0; seen_low = 1'b0;
        cmd_valid = 1'b1; cmd_byte = zb[0]; cmd_dc = 1'b0; cmd_last = 1'b0;
        for (int c = 0; c < 30 && zi < 4; c++) begin
            @(negedge clk);
            cx = cmd_valid && cmd_ready_z;
            track_cs(cs_n_z);
            if (cx) begin
                chk($sformatf("gap0_byte%0d", zi), tx_byte_z, zb[zi]);
                zi++;
            end
            tick;
            if (cx) begin
                if (zi < 4) begin
                    cmd_byte = zb[zi]; cmd_dc = zi[0]; cmd_last = zi[0];
                end else cmd_valid = 1'b0;
            end
        end
        chk("gap0_count", zi, 4);
        chk("gap0_runs", hi_runs.size(), 1);
        foreach (hi_runs[i]) chk("gap0_high_len", hi_runs[i], 1);

        // Randomized traffic against per-channel packet queues.
        do_reset;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) cq.push_back('{8'($urandom_range(0, 255)), j != 0, j == len - 1});
        end
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) pq.push_back('{8'($urandom_range(0, 255)), 1'b1, j == len - 1});
        end
        hi = 0; seen_low = 1'b0; win_ch = 0; wbytes = 0; last_seen = 1'b0; pp_seen = 1'b0;
        for (int c = 0; c < 5000 && (cq.size() > 0 || pq.size() > 0); c++) begin
            @(negedge clk);
            cx = cmd_valid && cmd_ready;
            px = pix_valid && pix_ready;
            if (cs_n) begin
                if (win_ch == 1) chk("rnd_cmd_whole", last_seen, 1);
                if (win_ch == 2) chk("rnd_pix_end", last_seen || (pp_seen && wbytes >= 8), 1);
                win_ch = 0;
                hi++;
            end else begin
                if (hi > 0) begin
                    if (seen_low) chk("rnd_gap", hi >= 5, 1);
                    seen_low = 1'b1; hi = 0; wbytes = 0; pp_seen = 1'b0; last_seen = 1'b0;
                end
                exp_pp = win_ch == 2 && wbytes >= 8 && cmd_valid;
                chk("rnd_preempt", pix_preempted, exp_pp);
                if (pix_preempted) pp_seen = 1'b1;
            end
            if (cx || px) begin
                ch = cx ? 1 : 2;
                if (win_ch == 0) win_ch = ch;
                else chk("rnd_same_channel", ch, win_ch);
                e = cx ? cq[0] : pq[0];
                chk("rnd_byte", {tx_byte, tx_dc}, {e.b, e.dc});
                chk("rnd_frame", {cs_n, tx_valid}, 2'b01);
                wbytes++;
                last_seen = e.last;
            end
            tick;
            if (cx) void'(cq.pop_front());
            if (px) void'(pq.pop_front());
            if (!(cmd_valid && !cx)) cmd_valid = cq.size() > 0 && $urandom_range(0, 1) == 1;
            if (cq.size() > 0) begin
                cmd_byte = cq[0].b; cmd_dc = cq[0].dc; cmd_last = cq[0].last;
            end
            if (!(pix_valid && !px)) pix_valid = pq.size() > 0 && $urandom_range(0, 1) == 1;
            if (pq.size() > 0) begin
                pix_byte = pq[0].b; pix_last = pq[0].last;
            end
            tx_ready = $urandom_range(0, 3) != 0;
        end
        chk("rnd_cmd_drained", cq.size(), 0);
        chk("rnd_pix_drained", pq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single LCD byte serializer (SPI + RS line) between two requesters.
- Command channel: init/config/window commands issued by the console core. Pixel channel: stream from the raster/scaler path.
- Arbitrates at packet boundaries, drives chip-select framing with a guaranteed inter-packet gap, and bounds pixel bursts so commands are never starved.
- Sits between the chip/raster logic and the LCD byte transmitter, in the clk_2 domain.

Parameters:
- GAP_CYCLES, 4, cycles cs_n held high between packets (0 = no gap state).
- MAX_BURST, 1024, max pixel bytes per grant before a pending command may preempt (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command byte valid
- cmd_ready  out  1  command byte accepted
- cmd_byte  in  8  command/parameter byte
- cmd_dc  in  1  0 = command, 1 = parameter data
- cmd_last  in  1  final byte of command packet
- pix_valid  in  1  pixel byte valid
- pix_ready  out  1  pixel byte accepted
- pix_byte  in  8  pixel byte
- pix_last  in  1  final byte of frame/packet
- pix_preempted  out  1  one-cycle pulse: pixel packet cut by burst limit
- tx_valid  out  1  byte to serializer valid
- tx_ready  in  1  serializer accepts byte
- tx_byte  out  8  byte to serializer
- tx_dc  out  1  drives LCD RS
- cs_n  out  1  LCD chip select, active low
- busy  out  1  high in any state except IDLE

Behaviour:
- Handshake: a byte transfers on a cycle with valid && ready. Upstream must hold byte/dc/last stable while valid && !ready.
- States: IDLE, CMD, PIX, GAP. Reset → IDLE, asynchronously.
- Reset values: cs_n=1, tx_valid=0, tx_byte=0, tx_dc=0, cmd_ready=0, pix_ready=0, pix_preempted=0, busy=0. Burst and gap counters are 0.
- IDLE:
  - cmd_valid → CMD (priority). Else pix_valid → PIX. Else stay.
  - The grant takes effect the cycle after the request is seen. Nothing is forwarded from IDLE.
- CMD:
  - cs_n=0; tx_valid=cmd_valid, tx_byte=cmd_byte, tx_dc=cmd_dc, cmd_ready=tx_ready. Combinational, zero latency.
  - pix_ready=0.
  - Transfer with cmd_last → GAP (or IDLE if GAP_CYCLES=0).
- PIX:
  - cs_n=0; tx_valid=pix_valid, tx_byte=pix_byte, tx_dc=1, pix_ready=tx_ready (unless preempt is asserted).
  - The burst counter increments per transfer and clears on entry to PIX.
  - Transfer with pix_last → GAP/IDLE.
  - Preempt: counter == MAX_BURST && cmd_valid, evaluated on a cycle with no transfer in progress.
    - pix_ready=0 and tx_valid=0 that cycle.
    - Pulse pix_preempted; → GAP.
    - Upstream must re-issue a memory-write-continue before resuming.
  - At the limit with no cmd_valid: keep streaming; the counter saturates at MAX_BURST.
- GAP: cs_n=1, all readies 0, counts GAP_CYCLES cycles, then → IDLE.
- Simultaneous cmd_valid and pix_valid in IDLE: command wins.
- Requests arriving during GAP are held and evaluated in IDLE.
- cmd_valid dropping mid-packet (before last): stay in CMD with cs_n low, tx_valid=0. Packets are never abandoned.
- Reset mid-packet: immediate return to IDLE, cs_n=1. The partial packet is lost and upstream restarts.

Optional Feature:
- Macro LCD_ARB_ROUND_ROBIN_EN.
- Defined: when both channels are pending in IDLE, grant alternates, using a 1-bit last_grant register (reset = pixel, so the first tie goes to command).
- Undefined: fixed command priority.
- Burst-limit preemption applies in both builds.

Decomposition:
- Shared package lcd_pkg: state encoding localparams (ARB_IDLE, ARB_CMD, ARB_PIX, ARB_GAP), DC_CMD=0 / DC_DATA=1 constants.
- One natural sub-module: lcd_arb_gap_timer, a loadable down-counter with a done flag, used for GAP.
- Burst counter stays inline.

Test Plan:
- cmd packet 0x2A,0x00,0x00,0x01,0x3F (dc 0,1,1,1,1; last on 5th), tx_ready=1 → tx_dc sequence 0,1,1,1,1.
  - cs_n low for exactly 5 transfer cycles, then high 4 cycles, then busy=0.
- cmd and pix both asserted in the same IDLE cycle → CMD granted first; pixel granted after its gap.
  - With LCD_ARB_ROUND_ROBIN_EN, a second tie grants pixel.
- MAX_BURST=8, pixel stream of 20 bytes, cmd_valid raised after byte 3 → exactly 8 pixel bytes sent.
  - pix_preempted pulses once; command packet follows after 4 gap cycles.
- tx_ready toggling 1,0,0,1 during CMD → bytes held stable; each byte is transferred exactly once, in order.
- Assert reset with 2 of 4 pixel bytes sent → cs_n=1 and tx_valid=0 immediately. After release: IDLE, counters 0.
- GAP_CYCLES=0, back-to-back cmd packets → cs_n high for exactly one IDLE cycle between packets.
